// File: rtl/ram_arbiter_if.sv
// Requester-side bus for the two-port RAM arbiter: command handshake
// plus read-return strobe for requesters A and B.
interface ram_arbiter_if;
   logic       a_req;
   logic       a_we;
   logic [5:0] a_addr;
   logic [7:0] a_wdata;
   logic       a_gnt;
   logic       a_rvalid;
   logic [7:0] a_rdata;

   logic       b_req;
   logic       b_we;
   logic [5:0] b_addr;
   logic [7:0] b_wdata;
   logic       b_gnt;
   logic       b_rvalid;
   logic [7:0] b_rdata;

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      input  a_gnt, a_rvalid, a_rdata,
      input  b_gnt, b_rvalid, b_rdata
   );

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      output a_gnt, a_rvalid, a_rdata,
      output b_gnt, b_rvalid, b_rdata
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one 64x8 single-port RAM between requesters
// A and B, with bounded bursts and a 2-stage read-return tag pipeline.
module ram_arbiter #(
   parameter int unsigned BURST_MAX = 4
) (
   input  logic         clk,
   input  logic         rst,
   ram_arbiter_if.slave bus,
   output logic [7:0]   ram_data,
   output logic [5:0]   ram_addr,
   output logic         ram_we,
   input  logic [7:0]   ram_q
);

   typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

   localparam logic [3:0] CntMax = 4'(BURST_MAX);

   state_e     state;
   logic       last;  // 0 = A granted most recently, 1 = B
   logic [3:0] cnt;
   logic       gnt_a, gnt_b;
   logic       p1_v, p1_b, p2_v, p2_b;
   logic       rd_a, rd_b;

   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!rst) begin
         case (state)
            StIdle: begin
               if (bus.a_req && bus.b_req) begin
                  gnt_a = last;
                  gnt_b = !last;
               end else begin
                  gnt_a = bus.a_req;
                  gnt_b = bus.b_req;
               end
            end
            StOwnA: begin
               if (bus.a_req) begin
                  if (!bus.b_req || cnt < CntMax) gnt_a = 1'b1;
                  else gnt_b = 1'b1;
               end else begin
                  gnt_b = bus.b_req;
               end
            end
            StOwnB: begin
               if (bus.b_req) begin
                  if (!bus.a_req || cnt < CntMax) gnt_b = 1'b1;
                  else gnt_a = 1'b1;
               end else begin
                  gnt_a = bus.a_req;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= StIdle;
         last     <= 1'b1;
         cnt      <= 4'd0;
         ram_we   <= 1'b0;
         ram_addr <= 6'd0;
         ram_data <= 8'd0;
         p1_v     <= 1'b0;
         p1_b     <= 1'b0;
         p2_v     <= 1'b0;
         p2_b     <= 1'b0;
      end else begin
         if (gnt_a) begin
            state    <= StOwnA;
            last     <= 1'b0;
            cnt      <= (state != StOwnA) ? 4'd1 : (cnt < CntMax) ? cnt + 4'd1 : cnt;
            ram_we   <= bus.a_we;
            ram_addr <= bus.a_addr;
            ram_data <= bus.a_wdata;
         end else if (gnt_b) begin
            state    <= StOwnB;
            last     <= 1'b1;
            cnt      <= (state != StOwnB) ? 4'd1 : (cnt < CntMax) ? cnt + 4'd1 : cnt;
            ram_we   <= bus.b_we;
            ram_addr <= bus.b_addr;
            ram_data <= bus.b_wdata;
         end else begin
            // No grant here means nobody is requesting.
            state    <= StIdle;
            ram_we   <= 1'b0;
         end
         p1_v <= (gnt_a && !bus.a_we) || (gnt_b && !bus.b_we);
         p1_b <= gnt_b;
         p2_v <= p1_v;
         p2_b <= p1_b;
      end
   end

   assign rd_a = p2_v && !p2_b;
   assign rd_b = p2_v && p2_b;

   assign bus.a_gnt    = gnt_a;
   assign bus.b_gnt    = gnt_b;
   assign bus.a_rvalid = rd_a;
   assign bus.b_rvalid = rd_b;
   assign bus.a_rdata  = rd_a ? ram_q : 8'd0;
   assign bus.b_rdata  = rd_b ? ram_q : 8'd0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (BURST_MAX = 4) with a behavioural
// 64x8 synchronous RAM that reloads addr = value while rst is high.
module tb_ram_arbiter;

   logic       clk;
   logic       rst;
   logic [7:0] ram_data;
   logic [5:0] ram_addr;
   logic       ram_we;
   logic [7:0] ram_q;
   logic [7:0] mem [64];

   int total = 0;
   int bad   = 0;

   ram_arbiter_if bus ();

   ram_arbiter #(.BURST_MAX(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .ram_data (ram_data),
      .ram_addr (ram_addr),
      .ram_we   (ram_we),
      .ram_q    (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
         ram_q <= 8'd0;
      end else begin
         if (ram_we) mem[ram_addr] <= ram_data;
         ram_q <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic req, input logic we, input logic [5:0] addr,
                          input logic [7:0] wdata);
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
   endtask

   task automatic drive_b(input logic req, input logic we, input logic [5:0] addr,
                          input logic [7:0] wdata);
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
   endtask

   initial begin
      rst = 1'b1;
      drive_a(1'b0, 1'b0, 6'd0, 8'd0);
      drive_b(1'b0, 1'b0, 6'd0, 8'd0);
      #1;
      drive_a(1'b1, 1'b0, 6'd7, 8'd0);
      drive_b(1'b1, 1'b0, 6'd8, 8'd0);
      #1;
      chk("rst_a_gnt", {7'd0, bus.a_gnt}, 8'd0);
      chk("rst_b_gnt", {7'd0, bus.b_gnt}, 8'd0);
      @(posedge clk);
      step();
      chk("rst_ram_we", {7'd0, ram_we}, 8'd0);
      chk("rst_ram_addr", {2'd0, ram_addr}, 8'd0);
      chk("rst_ram_data", ram_data, 8'd0);
      chk("rst_rvalid", {6'd0, bus.a_rvalid, bus.b_rvalid}, 8'd0);
      rst = 1'b0;
      #1;

      // First tie after reset goes to A; B follows once A drops
      chk("tie_gnt", {6'd0, bus.a_gnt, bus.b_gnt}, 8'b10);
      step();
      drive_a(1'b0, 1'b0, 6'd0, 8'd0);
      #1;
      chk("tie_b_next", {6'd0, bus.a_gnt, bus.b_gnt}, 8'b01);
      chk("tie_ram_addr", {2'd0, ram_addr}, 8'd7);
      chk("tie_ram_we", {7'd0, ram_we}, 8'd0);
      step();
      drive_b(1'b0, 1'b0, 6'd0, 8'd0);
      chk("tie_a_rvalid", {7'd0, bus.a_rvalid}, 8'd1);
      chk("tie_a_rdata", bus.a_rdata, 8'd7);
      chk("tie_ram_addr_b", {2'd0, ram_addr}, 8'd8);
      step();
      chk("tie_b_rvalid", {6'd0, bus.a_rvalid, bus.b_rvalid}, 8'b01);
      chk("tie_b_rdata", bus.b_rdata, 8'd8);
      chk("tie_a_rdata0", bus.a_rdata, 8'd0);
      step();

      // A alone: 10 back-to-back reads of addr 0..9
      for (int c = 0; c < 13; c++) begin
         if (c < 10) drive_a(1'b1, 1'b0, 6'(c), 8'd0);
         else drive_a(1'b0, 1'b0, 6'd0, 8'd0);
         #1;
         if (c < 10) chk("seq_a_gnt", {7'd0, bus.a_gnt}, 8'd1);
         chk("seq_a_rvalid", {7'd0, bus.a_rvalid}, {7'd0, (c >= 2 && c < 12)});
         chk("seq_b_rvalid", {7'd0, bus.b_rvalid}, 8'd0);
         if (c >= 2 && c < 12) chk("seq_a_rdata", bus.a_rdata, 8'(c - 2));
         step();
      end

      // Write 0x5A to addr 3, then read it straight back
      drive_a(1'b1, 1'b1, 6'd3, 8'h5A);
      #1;
      chk("wr_a_gnt", {7'd0, bus.a_gnt}, 8'd1);
      step();
      drive_a(1'b1, 1'b0, 6'd3, 8'h00);
      #1;
      chk("wr_ram_we", {7'd0, ram_we}, 8'd1);
      chk("wr_ram_addr", {2'd0, ram_addr}, 8'd3);
      chk("wr_ram_data", ram_data, 8'h5A);
      chk("rd3_a_gnt", {7'd0, bus.a_gnt}, 8'd1);
      step();
      drive_a(1'b0, 1'b0, 6'd0, 8'd0);
      chk("rd3_ram_we", {7'd0, ram_we}, 8'd0);
      chk("rd3_a_rvalid_early", {7'd0, bus.a_rvalid}, 8'd0);
      step();
      chk("rd3_a_rvalid", {7'd0, bus.a_rvalid}, 8'd1);
      chk("rd3_a_rdata", bus.a_rdata, 8'h5A);
      chk("rd3_b_rvalid", {7'd0, bus.b_rvalid}, 8'd0);
      step();
      chk("rd3_a_rvalid_done", {7'd0, bus.a_rvalid}, 8'd0);

      // Interleaved: A writes 0x11@1, B writes 0x22@2, then alternating reads
      for (int c = 0; c < 10; c++) begin
         drive_a(1'b0, 1'b0, 6'd0, 8'd0);
         drive_b(1'b0, 1'b0, 6'd0, 8'd0);
         if (c == 0) drive_a(1'b1, 1'b1, 6'd1, 8'h11);
         else if (c == 1) drive_b(1'b1, 1'b1, 6'd2, 8'h22);
         else if (c < 8 && c % 2 == 0) drive_a(1'b1, 1'b0, 6'd1, 8'd0);
         else if (c < 8) drive_b(1'b1, 1'b0, 6'd2, 8'd0);
         #1;
         if (c < 8) begin
            chk("il_gnt", {6'd0, bus.a_gnt, bus.b_gnt},
                (c == 0 || (c >= 2 && c % 2 == 0)) ? 8'b10 : 8'b01);
         end
         if (c >= 2) begin
            automatic int  iss   = c - 2;
            automatic logic exp_a = (iss >= 2 && iss <= 7 && iss % 2 == 0);
            automatic logic exp_b = (iss >= 2 && iss <= 7 && iss % 2 == 1);
            chk("il_a_rvalid", {7'd0, bus.a_rvalid}, {7'd0, exp_a});
            chk("il_b_rvalid", {7'd0, bus.b_rvalid}, {7'd0, exp_b});
            chk("il_a_rdata", bus.a_rdata, exp_a ? 8'h11 : 8'h00);
            chk("il_b_rdata", bus.b_rdata, exp_b ? 8'h22 : 8'h00);
         end
         step();
      end

      // Contention: last grant went to B, so A leads; bursts of 4 alternate
      for (int i = 0; i < 16; i++) begin
         drive_a(1'b1, 1'b0, 6'(i), 8'd0);
         drive_b(1'b1, 1'b0, 6'(i + 16), 8'd0);
         #1;
         chk("burst_gnt", {6'd0, bus.a_gnt, bus.b_gnt}, ((i / 4) % 2 == 0) ? 8'b10 : 8'b01);
         step();
      end
      drive_a(1'b0, 1'b0, 6'd0, 8'd0);
      drive_b(1'b0, 1'b0, 6'd0, 8'd0);
      step();
      step();
      step();

      // Asynchronous reset mid-cycle while a write sits on the RAM bus
      drive_a(1'b1, 1'b1, 6'd20, 8'h77);
      #1;
      chk("wrst_a_gnt", {7'd0, bus.a_gnt}, 8'd1);
      step();
      chk("wrst_ram_we_pre", {7'd0, ram_we}, 8'd1);
      chk("wrst_ram_addr_pre", {2'd0, ram_addr}, 8'd20);
      #2;
      rst = 1'b1;
      #1;
      chk("wrst_ram_we", {7'd0, ram_we}, 8'd0);
      chk("wrst_ram_addr", {2'd0, ram_addr}, 8'd0);
      chk("wrst_ram_data", ram_data, 8'd0);
      chk("wrst_a_gnt_in_rst", {7'd0, bus.a_gnt}, 8'd0);
      drive_a(1'b0, 1'b0, 6'd0, 8'd0);
      step();
      rst = 1'b0;
      #1;

      // Reset one cycle after a read grant discards that read
      drive_a(1'b1, 1'b0, 6'd9, 8'd0);
      #1;
      chk("rrst_a_gnt", {7'd0, bus.a_gnt}, 8'd1);
      step();
      drive_a(1'b0, 1'b0, 6'd0, 8'd0);
      chk("rrst_ram_addr_pre", {2'd0, ram_addr}, 8'd9);
      rst = 1'b1;
      #1;
      chk("rrst_ram_addr", {2'd0, ram_addr}, 8'd0);
      step();
      chk("rrst_rvalid_in_rst", {6'd0, bus.a_rvalid, bus.b_rvalid}, 8'd0);
      rst = 1'b0;
      step();
      chk("rrst_rvalid_1", {6'd0, bus.a_rvalid, bus.b_rvalid}, 8'd0);
      step();
      chk("rrst_rvalid_2", {6'd0, bus.a_rvalid, bus.b_rvalid}, 8'd0);
      drive_a(1'b1, 1'b0, 6'd5, 8'd0);
      #1;
      chk("rrst_next_gnt", {7'd0, bus.a_gnt}, 8'd1);
      step();
      drive_a(1'b0, 1'b0, 6'd0, 8'd0);
      step();
      chk("rrst_next_rvalid", {7'd0, bus.a_rvalid}, 8'd1);
      chk("rrst_next_rdata", bus.a_rdata, 8'd5);
      chk("rrst_next_b_rvalid", {7'd0, bus.b_rvalid}, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares the 64x8 single-port RAM between two requesters (A and B). It accepts one access per cycle from the winning requester and registers that access onto the RAM's data/addr/we inputs. It tracks outstanding reads and routes each read result back to the requester that issued it, with a valid strobe. It sits directly in front of the `ram` instance and is the only driver of its inputs.

## Interface
- BURST_MAX, default 4: maximum consecutive accepted accesses by one owner while the other requester is waiting; range 1..15.
- clk  in  1  rising-edge clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  A has a valid command this cycle.
- a_we  in  1  A command type: 1 = write, 0 = read.
- a_addr  in  6  A word address.
- a_wdata  in  8  A write data.
- a_gnt  out  1  combinational accept; the A command transfers when a_req && a_gnt.
- a_rvalid  out  1  A read data valid.
- a_rdata  out  8  A read data; meaningful only while a_rvalid = 1.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for B.
- ram_data  out  8  to RAM data.
- ram_addr  out  6  to RAM addr.
- ram_we  out  1  to RAM we.
- ram_q  in  8  from RAM q.

## Operation
- State machine has three states:
  - IDLE: no owner.
  - OWN_A: A is the current owner.
  - OWN_B: B is the current owner.
- The state machine also holds `last`, the requester granted most recently, and a burst counter `cnt` (4 bits).
- Grant decision is combinational from the current state and the req inputs. At most one gnt is high in any cycle.
- IDLE:
  - Only one requester requesting: grant it.
  - Both requesting: grant the one that is not `last`.
  - On a grant, go to OWN_x with cnt = 1.
- OWN_x, owner x still requesting:
  - If the other requester is idle, or cnt < BURST_MAX: grant x and increment cnt, saturating at BURST_MAX.
  - Otherwise (other is requesting and cnt = BURST_MAX): grant the other, go to OWN_other, set cnt = 1.
- OWN_x, owner x not requesting:
  - Other requesting: grant the other, go to OWN_other, set cnt = 1.
  - Neither requesting: go to IDLE, leave cnt unchanged.
- `last` is updated to the granted requester on every grant.
- On an accepted command, the arbiter registers the winner's we, addr and wdata into ram_we, ram_addr and ram_data at the next edge.
- With no accepted command, ram_we is registered 0. ram_addr and ram_data hold their previous values.
- Read return:
  - Each accepted read pushes a tag (the requester id) into a 2-stage shift pipeline. Writes push an empty slot.
  - When a tagged slot reaches stage 2, the tagged requester's rvalid = 1 and its rdata = ram_q.
  - The other requester's rdata = 0.
- Writes produce no response.
- Read-after-write to the same address, accepted in consecutive cycles, returns the new data. This follows from RAM write ordering; no forwarding logic is needed.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets:
  - state = IDLE, last = B (so A wins the first tie), cnt = 0.
  - ram_we = 0, ram_addr = 0, ram_data = 0.
  - rvalid pipeline cleared, so a_rvalid = b_rvalid = 0.
  - gnt outputs are 0 while rst = 1.
- Access accepted in cycle N:
  - Appears on the ram_* outputs in cycle N+1.
  - The RAM captures it at the end of N+1.
  - For a read, rvalid is high in cycle N+2 and rdata = ram_q in that cycle.
- Fixed read latency is 2 cycles. Throughput is one access per cycle, back-to-back, with no bubbles at owner switches.
- Requesters hold req and command fields stable until they see gnt. A command may be dropped only after it has been granted.
- Reset asserted mid-operation discards any in-flight reads: no rvalid is issued for them and ram_we drops to 0 immediately.
- cnt never exceeds BURST_MAX. With BURST_MAX = 1, both requesters requesting continuously get strictly alternating grants.

## Test plan
- Reset: rst pulse mid-cycle -> all outputs 0 asynchronously. After release, both req = 1 -> a_gnt = 1 first.
- Single requester: A writes 0x5A to addr 3 (cycle N), then reads addr 3 (N+1) -> ram_we = 1 in N+1, a_rvalid = 1 with a_rdata = 0x5A in N+3, b_rvalid stays 0.
- Contention with BURST_MAX = 4, A and B both requesting continuously -> grant pattern AAAA BBBB AAAA..., never 5 consecutive grants to one requester.
- A alone, 10 back-to-back reads of addrs 0..9 (preloaded addr = value) -> a_gnt held high, a_rvalid high for 10 consecutive cycles, rdata = 0..9 in order.
- Interleaved reads: A reads addr 1 (0x11), B reads addr 2 (0x22) on alternate cycles -> each rvalid carries only its own data, exactly 2 cycles after its grant.
- Reset asserted one cycle after a read grant -> no rvalid ever produced for that read. The next granted read returns correct data.
